// File: rtl/minterm_lut_eval_pkg.sv
// Shared defaults and state encoding for the minterm LUT evaluator.
package minterm_lut_eval_pkg;

    localparam int unsigned N_IN_DEFAULT = 5;
    localparam logic [31:0] INIT_DEFAULT = 32'h0A3E_8C4C;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

endpackage

// File: rtl/minterm_table.sv
// 2^N_IN-bit truth table: one write port, two asynchronous read ports.
module minterm_table import minterm_lut_eval_pkg::*; #(
    parameter int unsigned            N_IN = N_IN_DEFAULT,
    parameter logic [(2**N_IN)-1:0]   INIT = INIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [N_IN-1:0] wr_addr,
    input  logic            wr_bit,
    input  logic [N_IN-1:0] eval_addr,
    output logic            eval_bit,
    input  logic [N_IN-1:0] sweep_addr,
    output logic            sweep_bit
);

    logic [(2**N_IN)-1:0] tbl;

    // Table storage: reloads INIT on reset, single-bit write otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= INIT;
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_bit;
        end
    end

    assign eval_bit  = tbl[eval_addr];
    assign sweep_bit = tbl[sweep_addr];

endmodule

// File: rtl/minterm_lut_eval.sv
// Programmable sum-of-minterms unit with registered evaluate and self-check sweep.
module minterm_lut_eval import minterm_lut_eval_pkg::*; #(
    parameter int unsigned            N_IN = N_IN_DEFAULT,
    parameter logic [(2**N_IN)-1:0]   INIT = INIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [N_IN-1:0] cfg_addr,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vars,
    output logic            in_ready,
    output logic            out_valid,
    output logic            f_out,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic [N_IN:0]   ones_count,
    output logic            any_one,
    output logic [N_IN-1:0] first_one
);

    localparam int unsigned  DEPTH    = 2**N_IN;
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [N_IN:0]   sweep_idx;
    logic [N_IN:0]   acc_count, acc_count_nxt;
    logic [N_IN-1:0] acc_first, acc_first_nxt;
    logic            eval_bit, sweep_bit;
    logic            idle, last_idx;

    assign idle     = (state_q == IDLE);
    assign last_idx = (sweep_idx == LAST_IDX);

    minterm_table #(
        .N_IN (N_IN),
        .INIT (INIT)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cfg_we && idle),
        .wr_addr    (cfg_addr),
        .wr_bit     (cfg_bit),
        .eval_addr  (in_vars),
        .eval_bit   (eval_bit),
        .sweep_addr (sweep_idx[N_IN-1:0]),
        .sweep_bit  (sweep_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sweep_start) state_d = SWEEP;
            SWEEP:   if (last_idx)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulator update for the table bit at the current sweep index.
    always_comb begin
        acc_count_nxt = acc_count;
        acc_first_nxt = acc_first;
        if (sweep_bit) begin
            acc_count_nxt = acc_count + 1'b1;
            if (acc_count == '0) acc_first_nxt = sweep_idx[N_IN-1:0];
        end
    end

    // Sweep index, accumulators and result registers.
    // Results load on the final SWEEP edge (using the final accumulator value)
    // so they are already stable during the DONE cycle that pulses sweep_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_idx  <= '0;
            acc_count  <= '0;
            acc_first  <= '0;
            ones_count <= '0;
            any_one    <= 1'b0;
            first_one  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        sweep_idx <= '0;
                        acc_count <= '0;
                        acc_first <= '0;
                    end
                end
                SWEEP: begin
                    acc_count <= acc_count_nxt;
                    acc_first <= acc_first_nxt;
                    if (last_idx) begin
                        ones_count <= acc_count_nxt;
                        first_one  <= acc_first_nxt;
                        any_one    <= (acc_count_nxt != '0);
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered evaluate path; table is read before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f_out     <= 1'b0;
        end else begin
            out_valid <= in_valid && idle;
            if (in_valid && idle) f_out <= eval_bit;
        end
    end

    assign cfg_ready  = idle;
    assign in_ready   = idle;
    assign sweep_busy = (state_q == SWEEP);
    assign sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_minterm_lut_eval.sv
// Self-checking bench for minterm_lut_eval against a truth-table array model.
module tb_minterm_lut_eval;

    localparam int          N     = 5;
    localparam int          DEPTH = 32;
    localparam logic [31:0] INIT_V = 32'h0A3E_8C4C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [N-1:0] cfg_addr;
    logic         cfg_bit;
    logic         cfg_ready;
    logic         in_valid;
    logic [N-1:0] in_vars;
    logic         in_ready;
    logic         out_valid;
    logic         f_out;
    logic         sweep_start;
    logic         sweep_busy;
    logic         sweep_done;
    logic [N:0]   ones_count;
    logic         any_one;
    logic [N-1:0] first_one;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic model [DEPTH];

    minterm_lut_eval #(
        .N_IN (N),
        .INIT (INIT_V)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_bit     (cfg_bit),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .in_vars     (in_vars),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .f_out       (f_out),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .ones_count  (ones_count),
        .any_one     (any_one),
        .first_one   (first_one)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        logic [31:0] v;
        v = INIT_V;
        for (int i = 0; i < DEPTH; i++) model[i] = v[i];
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (model[i]) c++;
        return c;
    endfunction

    function automatic int model_first();
        for (int i = 0; i < DEPTH; i++) if (model[i]) return i;
        return 0;
    endfunction

    task automatic do_eval(input int addr);
        in_valid = 1'b1;
        in_vars  = N'(addr);
        tick();
        in_valid = 1'b0;
        check("eval_valid", out_valid, 1);
        check($sformatf("eval_f[%0d]", addr), f_out, model[addr]);
        tick();
        check("eval_pulse_end", out_valid, 0);
    endtask

    task automatic do_write(input int addr, input logic b);
        cfg_we   = 1'b1;
        cfg_addr = N'(addr);
        cfg_bit  = b;
        tick();
        cfg_we = 1'b0;
        model[addr] = b;
    endtask

    // Runs a full sweep; any cfg_we already driven lands at the start edge.
    task automatic do_sweep(input bit disturb);
        int exp_c, exp_f;
        exp_c = model_count();
        exp_f = model_first();
        check("sweep_ready_before", cfg_ready, 1);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        cfg_we      = 1'b0;
        check("sweep_in_ready_low", in_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check("sweep_busy", sweep_busy, 1);
            check("sweep_done_early", sweep_done, 0);
            if (disturb && i == 5) begin
                cfg_we      = 1'b1;
                cfg_addr    = N'(6);
                cfg_bit     = ~model[6];
                in_valid    = 1'b1;
                in_vars     = N'(6);
                sweep_start = 1'b1;
            end
            tick();
            if (disturb && i == 5) begin
                cfg_we      = 1'b0;
                in_valid    = 1'b0;
                sweep_start = 1'b0;
                check("sweep_no_out_valid", out_valid, 0);
            end
        end
        check("sweep_done", sweep_done, 1);
        check("sweep_busy_off", sweep_busy, 0);
        check("ones_count", ones_count, exp_c);
        check("any_one", any_one, (exp_c != 0) ? 1 : 0);
        check("first_one", first_one, exp_f);
        tick();
        check("sweep_done_end", sweep_done, 0);
        check("sweep_idle_again", cfg_ready, 1);
    endtask

    initial begin
        int a, prev;
        logic b;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bit = 1'b0;
        in_valid = 1'b0; in_vars = '0; sweep_start = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_f_out", f_out, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_count", ones_count, 0);
        check("rst_any", any_one, 0);
        check("rst_first", first_one, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Directed evaluates from the reset table.
        do_eval(2); do_eval(0); do_eval(27);
        do_sweep(0);
        check("init_count_13", ones_count, 13);
        check("init_first_2", first_one, 2);

        do_write(2, 1'b0);
        do_write(31, 1'b1);
        do_sweep(0);
        check("w_count_13", ones_count, 13);
        check("w_first_3", first_one, 3);
        do_eval(31);

        // Write and evaluate of the same address on one edge return the old value.
        cfg_we = 1'b1; cfg_addr = N'(31); cfg_bit = 1'b0;
        in_valid = 1'b1; in_vars = N'(31);
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        check("rbw_valid", out_valid, 1);
        check("rbw_old", f_out, 1);
        model[31] = 1'b0;
        tick();
        do_eval(31);

        // Write together with sweep_start: the sweep sees the new value.
        cfg_we = 1'b1; cfg_addr = N'(0); cfg_bit = 1'b1;
        model[0] = 1'b1;
        do_sweep(0);
        check("ws_first_0", first_one, 0);

        for (int i = 0; i < DEPTH; i++) do_write(i, 1'b0);
        do_sweep(0);
        for (int i = 0; i < DEPTH; i++) do_write(i, 1'b1);
        do_sweep(0);
        check("all_ones_32", ones_count, 32);

        // Random writes and evaluates.
        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(DEPTH - 1));
            if ($urandom_range(1) == 1) do_write(a, 1'(($urandom_range(1))));
            else do_eval(a);
        end
        do_sweep(0);
        do_sweep(1);

        // Back-to-back evaluates at full throughput.
        prev = int'($urandom_range(DEPTH - 1));
        in_valid = 1'b1; in_vars = N'(prev);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("b2b_valid", out_valid, 1);
            check($sformatf("b2b_f[%0d]", prev), f_out, model[prev]);
            prev = int'($urandom_range(DEPTH - 1));
            in_vars = N'(prev);
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a sweep.
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (10) tick();
        check("mid_busy", sweep_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_busy", sweep_busy, 0);
        check("mr_done", sweep_done, 0);
        check("mr_count", ones_count, 0);
        check("mr_any", any_one, 0);
        check("mr_first", first_one, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_f_out", f_out, 0);
        check("mr_cfg_ready", cfg_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_eval(2);
        do_eval(31);
        do_sweep(0);
        check("mr_sweep_13", ones_count, 13);

        // Random table followed by random evaluates and a disturbed sweep.
        for (int i = 0; i < DEPTH; i++) begin
            b = 1'($urandom_range(1));
            do_write(i, b);
        end
        for (int k = 0; k < 8; k++) do_eval(int'($urandom_range(DEPTH - 1)));
        do_sweep(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
